// File: rtl/wallace_tree_pkg.sv
// rtl/wallace_tree_pkg.sv - shared types, widths and helpers for the Wallace-tree multiplier
// Purpose: operand/product widths, state encoding and the partial-product generator.
// Ports: none (package).
package wallace_tree_pkg;

  localparam int N = 16;
  localparam int W = 2 * N;

  typedef logic [N-1:0] operand_t;
  typedef logic [W-1:0] product_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSA  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Row i of the partial-product matrix: multiplicand gated by bit i of the multiplier.
  function automatic product_t partial_product(input operand_t a, input operand_t b, input int i);
    product_t w_row;
    w_row = {{N{1'b0}}, (b & {N{a[i]}})};
    return w_row << i;
  endfunction

endpackage

// File: rtl/wallace_tree_csa_row.sv
// rtl/wallace_tree_csa_row.sv - W-bit 3:2 carry-save compressor row
// Purpose: reduce three W-bit rows to a sum row and a weight-aligned carry row.
// Ports:
//   a, b, c : input rows (W bits)
//   sum     : bitwise a^b^c
//   carry   : bitwise majority(a,b,c), shifted left by one (bit W is dropped)
module csa_row
  import wallace_tree_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/wallace_tree.sv
// rtl/wallace_tree.sv - 16x16 unsigned multiplier with Wallace-tree reducer and 2-cycle Run sequence
// Purpose: load operands, then on Run register the tree's sum/carry rows (CSA) and their final sum (ADD).
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   Run                 : start command; must drop to 0 before another run can start
//   ClearA_LoadB        : in IDLE (and Run low) loads MUR/MUD and clears the result registers
//   MUR, MUD            : multiplier / multiplicand operands
//   result              : registered product
//   result1, result2    : registered sum and carry rows of the tree
//   test, test2         : operand registers (debug)
module wallace_tree
  import wallace_tree_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic         ClearA_LoadB,
  input  logic [N-1:0] MUR,
  input  logic [N-1:0] MUD,
  output logic [W-1:0] result,
  output logic [W-1:0] result1,
  output logic [W-1:0] result2,
  output logic [N-1:0] test,
  output logic [N-1:0] test2
);

  state_t   r_state, w_state_next;
  operand_t r_op_a, r_op_b;
  product_t r_result, r_result1, r_result2;
  logic     w_load, w_csa, w_add;

  // Tree rows per level: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2
  product_t w_l0 [16];
  product_t w_l1 [11];
  product_t w_l2 [8];
  product_t w_l3 [6];
  product_t w_l4 [4];
  product_t w_l5 [3];
  product_t w_sum, w_carry;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_pp
    assign w_l0[gi] = partial_product(r_op_a, r_op_b, gi);
  end

  for (gi = 0; gi < 5; gi++) begin : g_lvl1
    csa_row u_csa (.a(w_l0[3*gi]), .b(w_l0[3*gi+1]), .c(w_l0[3*gi+2]),
                   .sum(w_l1[2*gi]), .carry(w_l1[2*gi+1]));
  end
  assign w_l1[10] = w_l0[15];

  for (gi = 0; gi < 3; gi++) begin : g_lvl2
    csa_row u_csa (.a(w_l1[3*gi]), .b(w_l1[3*gi+1]), .c(w_l1[3*gi+2]),
                   .sum(w_l2[2*gi]), .carry(w_l2[2*gi+1]));
  end
  assign w_l2[6] = w_l1[9];
  assign w_l2[7] = w_l1[10];

  for (gi = 0; gi < 2; gi++) begin : g_lvl3
    csa_row u_csa (.a(w_l2[3*gi]), .b(w_l2[3*gi+1]), .c(w_l2[3*gi+2]),
                   .sum(w_l3[2*gi]), .carry(w_l3[2*gi+1]));
  end
  assign w_l3[4] = w_l2[6];
  assign w_l3[5] = w_l2[7];

  for (gi = 0; gi < 2; gi++) begin : g_lvl4
    csa_row u_csa (.a(w_l3[3*gi]), .b(w_l3[3*gi+1]), .c(w_l3[3*gi+2]),
                   .sum(w_l4[2*gi]), .carry(w_l4[2*gi+1]));
  end

  csa_row u_lvl5 (.a(w_l4[0]), .b(w_l4[1]), .c(w_l4[2]), .sum(w_l5[0]), .carry(w_l5[1]));
  assign w_l5[2] = w_l4[3];

  csa_row u_lvl6 (.a(w_l5[0]), .b(w_l5[1]), .c(w_l5[2]), .sum(w_sum), .carry(w_carry));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_csa        = 1'b0;
    w_add        = 1'b0;
    case (r_state)
      IDLE: begin
        // Run wins over a simultaneous load; the run uses the registers as they stand.
        if (Run)               w_state_next = CSA;
        else if (ClearA_LoadB) w_load       = 1'b1;
      end
      CSA: begin
        w_csa        = 1'b1;
        w_state_next = ADD;
      end
      ADD: begin
        w_add        = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        // Wait for Run to drop so a held Run does not retrigger.
        if (!Run) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_result  <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_op_a    <= MUR;
        r_op_b    <= MUD;
        r_result  <= '0;
        r_result1 <= '0;
        r_result2 <= '0;
      end
      if (w_csa) begin
        r_result1 <= w_sum;
        r_result2 <= w_carry;
      end
      if (w_add) r_result <= r_result1 + r_result2;
    end
  end

  assign result  = r_result;
  assign result1 = r_result1;
  assign result2 = r_result2;
  assign test    = r_op_a;
  assign test2   = r_op_b;

endmodule

// File: tb/tb_wallace_tree.sv
// tb/tb_wallace_tree.sv - self-checking bench for wallace_tree
module tb_wallace_tree;

  logic        Clk = 1'b0;
  logic        Reset, Run, ClearA_LoadB;
  logic [15:0] MUR, MUD;
  logic [31:0] result, result1, result2;
  logic [15:0] test, test2;

  wallace_tree dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .MUR(MUR), .MUD(MUD), .result(result), .result1(result1), .result2(result2),
    .test(test), .test2(test2)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] mur;
    logic [15:0] mud;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_a, m_b;

  function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                          input string tag);
    ClearA_LoadB = 1'b1; Run = 1'b0; MUR = a; MUD = b;
    step();
    m_a = a; m_b = b;
    ClearA_LoadB = 1'b0;
    chk({tag, " test"}, 32'(test), 32'(a));
    chk({tag, " test2"}, 32'(test2), 32'(b));
    chk({tag, " cleared result"}, result, 32'h0);
    Run = 1'b1;
    step();
    step();
    chk({tag, " sum+carry"}, result1 + result2, exp);
    step();
    chk({tag, " result"}, result, exp);
    Run = 1'b0;
    step();
    chk({tag, " result persists"}, result, exp);
  endtask

  initial begin
    logic [15:0] ra, rb;
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; MUR = '0; MUD = '0;
    step();
    step();
    Reset = 1'b0;
    chk("reset result", result, 32'h0);
    chk("reset result1", result1, 32'h0);
    chk("reset result2", result2, 32'h0);
    chk("reset test", 32'(test), 32'h0);
    chk("reset test2", 32'(test2), 32'h0);

    vecs.push_back('{16'h000F, 16'h0007, 32'h0000_0069});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE_0001});
    vecs.push_back('{16'h8000, 16'h0002, 32'h0001_0000});
    vecs.push_back('{16'h0000, 16'h1234, 32'h0000_0000});
    vecs.push_back('{16'h0001, 16'hFFFF, 32'h0000_FFFF});
    for (int k = 0; k < 12; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      vecs.push_back('{ra, rb, model_mul(ra, rb)});
    end
    for (int k = 0; k < vecs.size(); k++)
      run_mult(vecs[k].mur, vecs[k].mud, vecs[k].exp, $sformatf("vec%0d", k));

    // Run held high through DONE must not disturb the outputs.
    ClearA_LoadB = 1'b1; MUR = 16'h1234; MUD = 16'h0056;
    step();
    m_a = 16'h1234; m_b = 16'h0056;
    ClearA_LoadB = 1'b0; Run = 1'b1;
    step(); step(); step();
    for (int k = 0; k < 10; k++) begin
      ClearA_LoadB = 1'b1; MUR = 16'hAAAA; MUD = 16'h5555;
      step();
      chk($sformatf("hold result %0d", k), result, model_mul(m_a, m_b));
      chk($sformatf("hold sum+carry %0d", k), result1 + result2, model_mul(m_a, m_b));
      chk($sformatf("hold test %0d", k), 32'(test), 32'(m_a));
    end
    ClearA_LoadB = 1'b0; Run = 1'b0;
    step();
    run_mult(16'd3, 16'd5, 32'h0000_000F, "after hold");

    // Reset while in CSA clears everything and the next run multiplies zeros.
    ClearA_LoadB = 1'b1; MUR = 16'h00AB; MUD = 16'h00CD;
    step();
    ClearA_LoadB = 1'b0; Run = 1'b1;
    step();
    Reset = 1'b1; Run = 1'b0;
    step();
    m_a = '0; m_b = '0;
    chk("midrun reset result", result, 32'h0);
    chk("midrun reset result1", result1, 32'h0);
    chk("midrun reset result2", result2, 32'h0);
    chk("midrun reset test", 32'(test), 32'h0);
    chk("midrun reset test2", 32'(test2), 32'h0);
    Reset = 1'b0; Run = 1'b1;
    step(); step(); step();
    chk("post-reset run result", result, model_mul(m_a, m_b));
    Run = 1'b0;
    step();

    // Run and ClearA_LoadB together: Run wins, old operands are used.
    run_mult(16'd7, 16'd9, 32'd63, "pre-combo");
    Run = 1'b1; ClearA_LoadB = 1'b1; MUR = 16'h1111; MUD = 16'h2222;
    step();
    ClearA_LoadB = 1'b0;
    chk("combo test", 32'(test), 32'(m_a));
    chk("combo test2", 32'(test2), 32'(m_b));
    step();
    chk("combo sum+carry", result1 + result2, model_mul(m_a, m_b));
    step();
    chk("combo result", result, model_mul(m_a, m_b));
    Run = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
